branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- EX-stage resolution unit; the consumer end of the 2-bit predictor's prediction path.
- Compares the actual beq/bne outcome against the prediction carried into EX (predicted_to_EX) and returns Wrong_prediction to the predictor.
- Issues a registered PC redirect and a timed front-end flush.
- Keeps saturating branch and mispredict counters for performance readout.

Parameters:
- PC_W, 32, width of PC, immediate and redirect target.
- CNT_W, 16, width of each performance counter.
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- EX_opcode  input  12  opcode in EX, compared against the codebase beq/bne constants.
- EX_valid  input  1  EX holds a real instruction (0 = bubble).
- EX_PC  input  PC_W  PC of the EX instruction.
- EX_imm  input  PC_W  sign-extended branch offset.
- EX_rs1_val  input  32  forwarded rs1 operand.
- EX_rs2_val  input  32  forwarded rs2 operand.
- predicted_to_EX  input  1  prediction made in ID for this instruction (1 = taken).
- actual_taken  output  1  combinational resolved outcome.
- Wrong_prediction  output  1  combinational mispredict strobe to the predictor.
- PC_redirect_valid  output  1  registered one-cycle redirect strobe to IF.
- PC_redirect  output  PC_W  registered corrected fetch address.
- flush  output  1  registered; squash IF/ID and ID/EX.
- busy  output  1  registered; high while in RECOVER.
- branch_count  output  CNT_W  resolved-branch counter.
- mispredict_count  output  CNT_W  mispredict counter.

Behaviour:
- is_br = EX_valid && (EX_opcode == beq || EX_opcode == bne) && state == IDLE.
- actual_taken = is_br && (beq ? rs1 == rs2 : rs1 != rs2). It is 0 when is_br = 0.
- Wrong_prediction = is_br && (actual_taken != predicted_to_EX). Combinational, same cycle, so the predictor samples it on the same edge it samples EX_opcode.
- Target: actual_taken ? EX_PC + EX_imm : EX_PC + 4. Arithmetic is modulo 2^PC_W; wrap is silent.
- FSM states are IDLE and RECOVER, with a 4-bit down-counter fcnt.
- IDLE with Wrong_prediction = 1 at edge E:
  - state <= RECOVER; fcnt <= FLUSH_CYCLES-1.
  - PC_redirect <= target; PC_redirect_valid <= 1; flush <= 1; busy <= 1.
- IDLE otherwise: PC_redirect_valid <= 0, flush <= 0, busy <= 0. PC_redirect holds its last value.
- RECOVER:
  - PC_redirect_valid <= 0 (it is high for exactly one cycle).
  - If fcnt == 0: state <= IDLE, flush <= 0, busy <= 0.
  - Else: fcnt <= fcnt-1, flush stays 1.
  - Net result: flush is high exactly FLUSH_CYCLES cycles starting the cycle after detection.
- Branches reaching EX during RECOVER are wrong-path: masked (is_br = 0), so Wrong_prediction = 0, actual_taken = 0, and no counting.
- A correct prediction causes no redirect and no flush.
- Counters:
  - branch_count += 1 on every edge with is_br = 1.
  - mispredict_count += 1 on every edge with Wrong_prediction = 1.
  - Both saturate at all-ones; no wrap.
- Reset (asynchronous, any time, including mid-RECOVER):
  - state = IDLE, fcnt = 0.
  - PC_redirect_valid = 0, PC_redirect = 0, flush = 0, busy = 0, both counters = 0.
  - No pending redirect survives reset.
  - Combinational outputs follow their inputs, gated by state = IDLE.
- Non-branch opcodes and bubbles: no effect; predicted_to_EX is ignored.
- Invariant: mispredict_count <= branch_count at all times.

Test Plan:
1. beq, rs1 = rs2 = 5, predicted_to_EX = 0, EX_PC = 0x100, EX_imm = 0x20 -> same cycle Wrong_prediction = 1, actual_taken = 1. Next cycle PC_redirect_valid = 1, PC_redirect = 0x120. flush high 2 cycles; mispredict_count = 1, branch_count = 1.
2. bne, rs1 = 3, rs2 = 3, predicted_to_EX = 1, EX_PC = 0x200 -> Wrong_prediction = 1, actual_taken = 0. Next cycle PC_redirect = 0x204.
3. beq taken, predicted_to_EX = 1 -> Wrong_prediction = 0, no redirect, no flush. branch_count increments, mispredict_count unchanged.
4. Mispredict followed by a mispredicting bne in EX during the first flush cycle -> second branch masked: Wrong_prediction = 0, counters unchanged, only one redirect pulse.
5. Assert rst during cycle 1 of RECOVER -> flush, busy, PC_redirect_valid, PC_redirect and both counters go to 0 immediately (asynchronously). The next mispredict after release behaves as in test 1.
6. CNT_W = 4, drive 20 mispredicting branches -> both counters stop at 15. Also EX_valid = 0 with a beq opcode -> no outputs and no counting.

Source files
------------

// File: rtl/branch_resolver_if.sv
// EX-stage branch resolution bus: branch operands in, resolved outcome,
// redirect, flush and performance counters out.
interface branch_resolver_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic [11:0]      EX_opcode;
  logic             EX_valid;
  logic [PC_W-1:0]  EX_PC;
  logic [PC_W-1:0]  EX_imm;
  logic [31:0]      EX_rs1_val;
  logic [31:0]      EX_rs2_val;
  logic             predicted_to_EX;
  logic             actual_taken;
  logic             Wrong_prediction;
  logic             PC_redirect_valid;
  logic [PC_W-1:0]  PC_redirect;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output EX_opcode, EX_valid, EX_PC, EX_imm, EX_rs1_val, EX_rs2_val, predicted_to_EX,
    input  actual_taken, Wrong_prediction, PC_redirect_valid, PC_redirect,
           flush, busy, branch_count, mispredict_count
  );

  modport slave (
    input  EX_opcode, EX_valid, EX_PC, EX_imm, EX_rs1_val, EX_rs2_val, predicted_to_EX,
    output actual_taken, Wrong_prediction, PC_redirect_valid, PC_redirect,
           flush, busy, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage beq/bne resolver: flags mispredictions to the predictor, issues a
// registered redirect plus a timed front-end flush, and counts branches.
module branch_resolver #(
  parameter int          PC_W         = 32,
  parameter int          CNT_W        = 16,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [11:0] BEQ_OPCODE   = 12'h063,
  parameter logic [11:0] BNE_OPCODE   = 12'h0e3
) (
  input logic          clk,
  input logic          rst,
  branch_resolver_if.slave br
);

  typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [3:0]       FCNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_STEP   = {{(PC_W-3){1'b0}}, 3'd4};

  state_t           state_r;
  logic [3:0]       fcnt_r;
  logic             redirect_valid_r;
  logic [PC_W-1:0]  redirect_r;
  logic             flush_r;
  logic             busy_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispredict_cnt_r;

  logic             is_beq_s;
  logic             is_bne_s;
  logic             is_br_s;
  logic             operands_eq_s;
  logic             taken_s;
  logic             wrong_s;
  logic [PC_W-1:0]  target_s;

  // Resolve outcome and target; branches arriving during recovery are wrong-path and masked.
  always_comb begin
    is_beq_s      = (br.EX_opcode == BEQ_OPCODE);
    is_bne_s      = (br.EX_opcode == BNE_OPCODE);
    is_br_s       = br.EX_valid && (is_beq_s || is_bne_s) && (state_r == IDLE);
    operands_eq_s = (br.EX_rs1_val == br.EX_rs2_val);
    if (is_br_s) begin
      if (is_beq_s) begin
        taken_s = operands_eq_s;
      end else begin
        taken_s = !operands_eq_s;
      end
    end else begin
      taken_s = 1'b0;
    end
    wrong_s = is_br_s && (taken_s != br.predicted_to_EX);
    if (taken_s) begin
      target_s = br.EX_PC + br.EX_imm;
    end else begin
      target_s = br.EX_PC + PC_STEP;
    end
  end

  // Recovery FSM: one-cycle redirect pulse, flush held for FLUSH_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      fcnt_r           <= 4'd0;
      redirect_valid_r <= 1'b0;
      redirect_r       <= {PC_W{1'b0}};
      flush_r          <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wrong_s) begin
            state_r          <= RECOVER;
            fcnt_r           <= FCNT_INIT;
            redirect_r       <= target_s;
            redirect_valid_r <= 1'b1;
            flush_r          <= 1'b1;
            busy_r           <= 1'b1;
          end else begin
            redirect_valid_r <= 1'b0;
            flush_r          <= 1'b0;
            busy_r           <= 1'b0;
          end
        end
        RECOVER: begin
          redirect_valid_r <= 1'b0;
          if (fcnt_r == 4'd0) begin
            state_r <= IDLE;
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            fcnt_r  <= fcnt_r - 4'd1;
            flush_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r          <= IDLE;
          fcnt_r           <= 4'd0;
          redirect_valid_r <= 1'b0;
          flush_r          <= 1'b0;
          busy_r           <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; a mispredict is always also a counted branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_r     <= {CNT_W{1'b0}};
      mispredict_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (is_br_s && (branch_cnt_r != CNT_MAX)) begin
        branch_cnt_r <= branch_cnt_r + CNT_ONE;
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (wrong_s && (mispredict_cnt_r != CNT_MAX)) begin
        mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
      end else begin
        mispredict_cnt_r <= mispredict_cnt_r;
      end
    end
  end

  assign br.actual_taken      = taken_s;
  assign br.Wrong_prediction  = wrong_s;
  assign br.PC_redirect_valid = redirect_valid_r;
  assign br.PC_redirect       = redirect_r;
  assign br.flush             = flush_r;
  assign br.busy              = busy_r;
  assign br.branch_count      = branch_cnt_r;
  assign br.mispredict_count  = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed table-driven bench for branch_resolver: a 16-bit-counter instance
// and a 4-bit-counter instance share the same stimulus.
module tb_branch_resolver;

  localparam logic [11:0] BEQ = 12'h063;
  localparam logic [11:0] BNE = 12'h0e3;
  localparam logic [11:0] ADD = 12'h033;

  typedef struct {
    logic [11:0] op;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        is_br;
    logic        taken;
    logic        wrong;
    logic [31:0] target;
  } vec_t;

  logic clk;
  logic rst;

  branch_resolver_if #(.PC_W(32), .CNT_W(16)) bus ();
  branch_resolver_if #(.PC_W(32), .CNT_W(4))  bus_s ();

  branch_resolver #(.PC_W(32), .CNT_W(16), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bus.slave)
  );

  branch_resolver #(.PC_W(32), .CNT_W(4), .FLUSH_CYCLES(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .br  (bus_s.slave)
  );

  assign bus_s.EX_opcode       = bus.EX_opcode;
  assign bus_s.EX_valid        = bus.EX_valid;
  assign bus_s.EX_PC           = bus.EX_PC;
  assign bus_s.EX_imm          = bus.EX_imm;
  assign bus_s.EX_rs1_val      = bus.EX_rs1_val;
  assign bus_s.EX_rs2_val      = bus.EX_rs2_val;
  assign bus_s.predicted_to_EX = bus.predicted_to_EX;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0;
  int exp_mp = 0;
  int sm_br = 0;
  int sm_mp = 0;
  vec_t tbl [10];
  vec_t v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.EX_opcode       = x.op;
    bus.EX_valid        = x.valid;
    bus.EX_rs1_val      = x.rs1;
    bus.EX_rs2_val      = x.rs2;
    bus.predicted_to_EX = x.pred;
    bus.EX_PC           = x.pc;
    bus.EX_imm          = x.imm;
  endtask

  task automatic bubble();
    bus.EX_valid = 1'b0;
    bus.EX_opcode = ADD;
  endtask

  task automatic count_edge(input logic br_i, input logic mp_i);
    if (br_i) begin
      exp_br++;
      if (sm_br < 15) sm_br++;
    end
    if (mp_i) begin
      exp_mp++;
      if (sm_mp < 15) sm_mp++;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " branch_count"}, bus.branch_count, exp_br);
    chk({tag, " mispredict_count"}, bus.mispredict_count, exp_mp);
    chk({tag, " small branch_count"}, bus_s.branch_count, sm_br);
    chk({tag, " small mispredict_count"}, bus_s.mispredict_count, sm_mp);
    chk({tag, " mp<=br"}, (bus.mispredict_count <= bus.branch_count), 1'b1);
  endtask

  // Apply one vector from IDLE and follow it through the whole recovery window.
  task automatic run_vec(input vec_t x, input string tag);
    drive(x);
    #1;
    chk({tag, " actual_taken"}, bus.actual_taken, x.taken);
    chk({tag, " Wrong_prediction"}, bus.Wrong_prediction, x.wrong);
    @(posedge clk); #1;
    count_edge(x.is_br, x.wrong);
    bubble();
    chk({tag, " redirect_valid c1"}, bus.PC_redirect_valid, x.wrong);
    chk({tag, " flush c1"}, bus.flush, x.wrong);
    chk({tag, " busy c1"}, bus.busy, x.wrong);
    if (x.wrong) chk({tag, " PC_redirect"}, bus.PC_redirect, x.target);
    chk_counters(tag);
    @(posedge clk); #1;
    chk({tag, " redirect_valid c2"}, bus.PC_redirect_valid, 1'b0);
    chk({tag, " flush c2"}, bus.flush, x.wrong);
    @(posedge clk); #1;
    chk({tag, " flush c3"}, bus.flush, 1'b0);
    chk({tag, " busy c3"}, bus.busy, 1'b0);
  endtask

  initial begin
    //            op   vld rs1           rs2           pred pc            imm           isbr tkn wrg target
    tbl[0] = '{BEQ, 1'b1, 32'd5,        32'd5,        1'b0, 32'h100,      32'h20,       1'b1, 1'b1, 1'b1, 32'h120};
    tbl[1] = '{BNE, 1'b1, 32'd3,        32'd3,        1'b1, 32'h200,      32'h40,       1'b1, 1'b0, 1'b1, 32'h204};
    tbl[2] = '{BEQ, 1'b1, 32'd7,        32'd7,        1'b1, 32'h300,      32'h10,       1'b1, 1'b1, 1'b0, 32'h310};
    tbl[3] = '{BNE, 1'b1, 32'd1,        32'd2,        1'b0, 32'hfffffff0, 32'h20,       1'b1, 1'b1, 1'b1, 32'h10};
    tbl[4] = '{BEQ, 1'b1, 32'd1,        32'd2,        1'b0, 32'h500,      32'h80,       1'b1, 1'b0, 1'b0, 32'h504};
    tbl[5] = '{BEQ, 1'b0, 32'd4,        32'd4,        1'b0, 32'h600,      32'h10,       1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{ADD, 1'b1, 32'd4,        32'd4,        1'b0, 32'h700,      32'h10,       1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{BNE, 1'b1, 32'd0,        32'hffffffff, 1'b1, 32'h400,      32'hfffffff8, 1'b1, 1'b1, 1'b0, 32'h3f8};
    tbl[8] = '{BEQ, 1'b1, 32'd1,        32'd2,        1'b1, 32'hfffffffc, 32'h40,       1'b1, 1'b0, 1'b1, 32'h0};
    tbl[9] = '{BNE, 1'b1, 32'h8000_0000, 32'h0,       1'b0, 32'h1000,     32'hfffff000, 1'b1, 1'b1, 1'b1, 32'h0};

    rst = 1'b1;
    bubble();
    bus.EX_PC = 32'h0; bus.EX_imm = 32'h0; bus.EX_rs1_val = 32'h0;
    bus.EX_rs2_val = 32'h0; bus.predicted_to_EX = 1'b0;
    #12;
    chk("reset redirect_valid", bus.PC_redirect_valid, 1'b0);
    chk("reset PC_redirect", bus.PC_redirect, 32'h0);
    chk("reset flush", bus.flush, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk_counters("reset");
    rst = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // A mispredicting branch in the first flush cycle is wrong-path and must be ignored.
    v = '{BEQ, 1'b1, 32'd5, 32'd5, 1'b0, 32'h500, 32'h8, 1'b1, 1'b1, 1'b1, 32'h508};
    drive(v); #1;
    chk("mask first Wrong_prediction", bus.Wrong_prediction, 1'b1);
    @(posedge clk); #1;
    count_edge(1'b1, 1'b1);
    v = '{BNE, 1'b1, 32'd1, 32'd2, 1'b0, 32'h900, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0};
    drive(v); #1;
    chk("mask Wrong_prediction", bus.Wrong_prediction, 1'b0);
    chk("mask actual_taken", bus.actual_taken, 1'b0);
    chk("mask redirect_valid", bus.PC_redirect_valid, 1'b1);
    chk("mask PC_redirect", bus.PC_redirect, 32'h508);
    @(posedge clk); #1;
    chk("mask redirect_valid c2", bus.PC_redirect_valid, 1'b0);
    chk("mask flush c2", bus.flush, 1'b1);
    chk_counters("mask");
    bubble();
    @(posedge clk); #1;
    chk("mask flush c3", bus.flush, 1'b0);
    chk("mask redirect_valid c3", bus.PC_redirect_valid, 1'b0);

    // Asynchronous reset in the middle of recovery clears everything immediately.
    drive(tbl[0]); #1;
    @(posedge clk); #1;
    count_edge(1'b1, 1'b1);
    bubble();
    chk("pre-rst flush", bus.flush, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    exp_br = 0; exp_mp = 0; sm_br = 0; sm_mp = 0;
    chk("async rst flush", bus.flush, 1'b0);
    chk("async rst busy", bus.busy, 1'b0);
    chk("async rst redirect_valid", bus.PC_redirect_valid, 1'b0);
    chk("async rst PC_redirect", bus.PC_redirect, 32'h0);
    chk_counters("async rst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post-rst flush", bus.flush, 1'b0);
    run_vec(tbl[0], "after rst");

    // Saturation of the 4-bit counters under 20 mispredicts.
    for (int i = 0; i < 20; i++) run_vec(tbl[1], $sformatf("sat%0d", i));
    chk("sat small branch_count", bus_s.branch_count, 4'd15);
    chk("sat small mispredict_count", bus_s.mispredict_count, 4'd15);
    chk("sat wide branch_count", bus.branch_count, 16'd21);
    run_vec(tbl[5], "bubble beq after sat");
    chk("final wide mispredict_count", bus.mispredict_count, 16'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
